// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: state encodings, default frame shape and
// oversampling constants. The transmit side imports the same package.
package uart_rx_pkg;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int OVERSAMPLE  = 16;
  localparam int MID_TICK    = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receive-result bundle between uart_rx and the rx flag/data buffer.
// Handshake: rx_done_tick is a one-cycle valid strobe with no ready; dout,
// frame_err and parity_err are meaningful in the strobe cycle (dout is also
// held afterwards), so the consumer must capture on the strobe.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic            rx_done_tick;
  logic [DBIT-1:0] dout;
  logic            frame_err;
  logic            parity_err;

  modport master (output rx_done_tick, output dout, output frame_err, output parity_err);
  modport slave  (input  rx_done_tick, input  dout, input  frame_err, input  parity_err);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchronizer for an asynchronous single-bit input.
// RST_VAL sets the value both flops take on reset (1 for an idle-high line).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture to resolve metastability before use.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling driven by an external s_tick enable.
// Optional parity stage is compiled in with the UART_RX_PARITY_EN macro.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int PAR_ODD = 0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx,
  input  logic      s_tick,
  uart_rx_if.master bus,
  output state_t    dbg_state
);

  // Tick counter is 4 bits for the 16x lattice, widened only if a long stop
  // period (1.5 or 2 stop bits) needs a larger terminal count.
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic            rx_s;
  state_t          state, state_n;
  logic [SW-1:0]   s, s_n;
  logic [NW-1:0]   n, n_n;
  logic [DBIT-1:0] shift, shift_n;
  logic            done_n, fe_n, pe_n;
`ifdef UART_RX_PARITY_EN
  logic            par, par_n;
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign dbg_state = state;

  // State, counters, shift register and registered result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      s                <= '0;
      n                <= '0;
      shift            <= '0;
      bus.dout         <= '0;
      bus.rx_done_tick <= 1'b0;
      bus.frame_err    <= 1'b0;
      bus.parity_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par              <= 1'b0;
`endif
    end else begin
      state            <= state_n;
      s                <= s_n;
      n                <= n_n;
      shift            <= shift_n;
      bus.rx_done_tick <= done_n;
      bus.frame_err    <= fe_n;
      bus.parity_err   <= pe_n;
      if (done_n) bus.dout <= shift;
`ifdef UART_RX_PARITY_EN
      par              <= par_n;
`endif
    end
  end

  // Next-state logic; counters move only on s_tick, IDLE/BRK react to rx_s directly.
  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    shift_n = shift;
    done_n  = 1'b0;
    fe_n    = 1'b0;
    pe_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_MID) begin
            if (rx_s) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_LAST) begin
            shift_n = {rx_s, shift[DBIT-1:1]};
            s_n     = '0;
            if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              n_n = n + 1'b1;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (s == S_LAST) begin
            par_n   = rx_s;
            s_n     = '0;
            state_n = STOP;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP) begin
            done_n  = 1'b1;
            fe_n    = ~rx_s;
`ifdef UART_RX_PARITY_EN
            pe_n    = (^shift) ^ par ^ (PAR_ODD != 0);
`endif
            s_n     = '0;
            // A low stop sample means a break may be in progress: re-arm only after rx_s returns high.
            state_n = rx_s ? IDLE : BRK;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      BRK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: s_tick every 4 clk (64 clk per bit), DBIT=8,
// SB_TICK=16. Parity test is included when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
  import uart_rx_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   rx = 1'b1;
  logic   s_tick;
  state_t dbg_state;
  logic [1:0] tdiv = 2'd0;
  int unsigned cyc = 0;

  int n_cmp = 0;
  int n_err = 0;

  // pulse monitor
  int unsigned done_cnt = 0;
  logic [7:0]  last_dout = 8'h00, prev_dout = 8'h00;
  logic        last_fe = 1'b0, prev_fe = 1'b0, last_pe = 1'b0;
  int unsigned last_cyc = 0, prev_cyc = 0;

  uart_rx_if #(.DBIT(8)) rif ();

  uart_rx #(.DBIT(8), .SB_TICK(16), .PAR_ODD(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .s_tick    (s_tick),
    .bus       (rif.master),
    .dbg_state (dbg_state)
  );

  // clock / tick generation
  always #5 clk = ~clk;
  always @(posedge clk) begin
    tdiv <= tdiv + 2'd1;
    cyc  <= cyc + 1;
  end
  assign s_tick = (tdiv == 2'd3);

  always @(negedge clk) begin
    if (rif.rx_done_tick) begin
      prev_dout = last_dout;
      prev_fe   = last_fe;
      prev_cyc  = last_cyc;
      last_dout = rif.dout;
      last_fe   = rif.frame_err;
      last_pe   = rif.parity_err;
      last_cyc  = cyc;
      done_cnt  = done_cnt + 1;
    end
  end

  // driver tasks (all changes on negedge)
  task automatic send_bit(input logic b);
    rx = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input logic has_par, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    if (has_par) send_bit(par);
    send_bit(stop);
  endtask

  task automatic idle(input int cycles);
    rx = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (rif.rx_done_tick !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", rif.rx_done_tick); end
    n_cmp++; if (rif.dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", rif.dout); end
    n_cmp++; if (rif.frame_err !== 1'b0) begin n_err++; $display("FAIL reset_fe: got %b want 0", rif.frame_err); end
    n_cmp++; if (rif.parity_err !== 1'b0) begin n_err++; $display("FAIL reset_pe: got %b want 0", rif.parity_err); end
    n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    reset = 1'b0;
    idle(64);
  endtask

  task automatic test_frame;
    int unsigned base = done_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    idle(64);
    n_cmp++; if (done_cnt - base !== 1) begin n_err++; $display("FAIL frame_pulses: got %0d want 1", done_cnt - base); end
    n_cmp++; if (last_dout !== 8'hA5) begin n_err++; $display("FAIL frame_dout: got %h want a5", last_dout); end
    n_cmp++; if (last_fe !== 1'b0) begin n_err++; $display("FAIL frame_fe: got %b want 0", last_fe); end
    n_cmp++; if (last_pe !== 1'b0) begin n_err++; $display("FAIL frame_pe: got %b want 0", last_pe); end
    n_cmp++; if (rif.dout !== 8'hA5) begin n_err++; $display("FAIL frame_dout_held: got %h want a5", rif.dout); end
  endtask

  task automatic test_false_start;
    int unsigned base = done_cnt;
    rx = 1'b0;
    repeat (12) @(negedge clk);
    idle(128);
    n_cmp++; if (done_cnt !== base) begin n_err++; $display("FAIL false_pulses: got %0d want %0d", done_cnt, base); end
    n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL false_state: got %0d want IDLE", dbg_state); end
    n_cmp++; if (rif.dout !== 8'hA5) begin n_err++; $display("FAIL false_dout: got %h want a5", rif.dout); end
  endtask

  task automatic test_frame_err;
    int unsigned base = done_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (192) @(negedge clk);
    n_cmp++; if (done_cnt - base !== 1) begin n_err++; $display("FAIL ferr_pulses: got %0d want 1", done_cnt - base); end
    n_cmp++; if (last_dout !== 8'h3C) begin n_err++; $display("FAIL ferr_dout: got %h want 3c", last_dout); end
    n_cmp++; if (last_fe !== 1'b1) begin n_err++; $display("FAIL ferr_fe: got %b want 1", last_fe); end
    n_cmp++; if (dbg_state !== BRK) begin n_err++; $display("FAIL ferr_brk_state: got %0d want BRK", dbg_state); end
    idle(64);
    n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL ferr_rearm_state: got %0d want IDLE", dbg_state); end
    n_cmp++; if (done_cnt - base !== 1) begin n_err++; $display("FAIL ferr_pulses_after: got %0d want 1", done_cnt - base); end
  endtask

  task automatic test_reset_mid;
    int unsigned base = done_cnt;
    logic [7:0] d = 8'h55;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    repeat (32) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (rif.rx_done_tick !== 1'b0) begin n_err++; $display("FAIL rmid_done: got %b want 0", rif.rx_done_tick); end
    n_cmp++; if (rif.dout !== 8'h00) begin n_err++; $display("FAIL rmid_dout: got %h want 00", rif.dout); end
    n_cmp++; if (rif.frame_err !== 1'b0) begin n_err++; $display("FAIL rmid_fe: got %b want 0", rif.frame_err); end
    n_cmp++; if (rif.parity_err !== 1'b0) begin n_err++; $display("FAIL rmid_pe: got %b want 0", rif.parity_err); end
    n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL rmid_state: got %0d want IDLE", dbg_state); end
    repeat (4) @(negedge clk);
    rx    = 1'b1;
    reset = 1'b0;
    idle(128);
    n_cmp++; if (done_cnt !== base) begin n_err++; $display("FAIL rmid_no_pulse: got %0d want %0d", done_cnt, base); end
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    idle(64);
    n_cmp++; if (done_cnt - base !== 1) begin n_err++; $display("FAIL rmid_pulses: got %0d want 1", done_cnt - base); end
    n_cmp++; if (last_dout !== 8'h55) begin n_err++; $display("FAIL rmid_dout_after: got %h want 55", last_dout); end
    n_cmp++; if (last_fe !== 1'b0) begin n_err++; $display("FAIL rmid_fe_after: got %b want 0", last_fe); end
  endtask

  task automatic test_back_to_back;
    int unsigned base = done_cnt;
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    idle(64);
    n_cmp++; if (done_cnt - base !== 2) begin n_err++; $display("FAIL b2b_pulses: got %0d want 2", done_cnt - base); end
    n_cmp++; if (prev_dout !== 8'h00) begin n_err++; $display("FAIL b2b_first: got %h want 00", prev_dout); end
    n_cmp++; if (last_dout !== 8'hFF) begin n_err++; $display("FAIL b2b_second: got %h want ff", last_dout); end
    n_cmp++; if (last_cyc - prev_cyc !== 640) begin n_err++; $display("FAIL b2b_spacing: got %0d want 640", last_cyc - prev_cyc); end
    n_cmp++; if ({prev_fe, last_fe} !== 2'b00) begin n_err++; $display("FAIL b2b_fe: got %b want 00", {prev_fe, last_fe}); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    idle(64);
    n_cmp++; if (last_pe !== 1'b1) begin n_err++; $display("FAIL par_bad: got %b want 1", last_pe); end
    n_cmp++; if (last_dout !== 8'h07) begin n_err++; $display("FAIL par_bad_dout: got %h want 07", last_dout); end
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    idle(64);
    n_cmp++; if (last_pe !== 1'b0) begin n_err++; $display("FAIL par_good: got %b want 0", last_pe); end
    n_cmp++; if (last_fe !== 1'b0) begin n_err++; $display("FAIL par_good_fe: got %b want 0", last_fe); end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_false_start();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
